// File: rtl/if_ctrl_if.sv
// if_ctrl_if: fetch-sequencer bus bundling the ifstage, decode and counter signals
interface if_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      instr;
    logic             br_req;
    logic [31:0]      br_immed;
    logic             halt;
    logic             ir_ready;
    logic             PC_sel;
    logic             PC_lden;
    logic [31:0]      PC_immed;
    logic [31:0]      ir;
    logic             ir_valid;
    logic [CNT_W-1:0] fetch_cnt;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        input  instr, br_req, br_immed, halt, ir_ready,
        output PC_sel, PC_lden, PC_immed, ir, ir_valid, fetch_cnt, stall_cnt
    );

    modport slave (
        output instr, br_req, br_immed, halt, ir_ready,
        input  PC_sel, PC_lden, PC_immed, ir, ir_valid, fetch_cnt, stall_cnt
    );
endinterface

// File: rtl/if_ctrl.sv
// if_ctrl: fetch sequencer driving PC load and the decode handshake; IF_CTRL_PERF_EN builds the perf counters
module if_ctrl #(
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic     clk,
    input  logic     reset,
    if_ctrl_if.master bus
);
    localparam logic [0:0] S_WAIT  = 1'b0;
    localparam logic [0:0] S_VALID = 1'b1;
    localparam logic [2:0] LAT     = 3'(MEM_LAT);

    logic [0:0]  state_q, state_d;
    logic [2:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] ir_q, ir_d;
    logic        vld_q, vld_d;
    logic        xfer;

    assign xfer = !reset && state_q == S_VALID && vld_q && !bus.halt && bus.ir_ready;

    // Count down the memory latency, capture the word, then hold it until decode takes it
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        ir_d       = ir_q;
        vld_d      = vld_q;
        if (state_q == S_WAIT) begin
            wait_cnt_d = wait_cnt_q - 3'd1;
            if (wait_cnt_q == 3'd1) begin
                ir_d    = bus.instr;
                vld_d   = 1'b1;
                state_d = S_VALID;
            end
        end else if (xfer) begin
            vld_d      = 1'b0;
            wait_cnt_d = LAT;
            state_d    = S_WAIT;
        end
    end

    // Sequencer state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_WAIT;
            wait_cnt_q <= LAT;
            ir_q       <= '0;
            vld_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            ir_q       <= ir_d;
            vld_q      <= vld_d;
        end
    end

    assign bus.PC_lden  = xfer;
    assign bus.PC_sel   = xfer & bus.br_req;
    assign bus.PC_immed = xfer ? bus.br_immed : 32'd0;
    assign bus.ir       = reset ? 32'd0 : ir_q;
    assign bus.ir_valid = !reset && vld_q && !bus.halt;

`ifdef IF_CTRL_PERF_EN
    logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating counts of transfers and of held-but-not-taken cycles
    always_comb begin
        fetch_cnt_d = (xfer && fetch_cnt_q != '1) ? fetch_cnt_q + CNT_W'(1) : fetch_cnt_q;
        stall_cnt_d = (vld_q && !xfer && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    end

    // Counter registers, cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.fetch_cnt = reset ? {CNT_W{1'b0}} : fetch_cnt_q;
    assign bus.stall_cnt = reset ? {CNT_W{1'b0}} : stall_cnt_q;
`else
    assign bus.fetch_cnt = {CNT_W{1'b0}};
    assign bus.stall_cnt = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_if_ctrl.sv
// tb_if_ctrl: directed and random stimulus on MEM_LAT=1 and MEM_LAT=3 instances against a timeline model
module tb_if_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr = '0;
    logic [31:0] br_immed = '0;
    logic        br_req = 1'b0;
    logic        halt = 1'b0;
    logic        ir_ready = 1'b0;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    if_ctrl_if #(.CNT_W(16)) b1();
    if_ctrl_if #(.CNT_W(3))  b3();

    assign b1.instr = instr;    assign b3.instr = instr;
    assign b1.br_req = br_req;  assign b3.br_req = br_req;
    assign b1.br_immed = br_immed; assign b3.br_immed = br_immed;
    assign b1.halt = halt;      assign b3.halt = halt;
    assign b1.ir_ready = ir_ready; assign b3.ir_ready = ir_ready;

    if_ctrl #(.MEM_LAT(1), .CNT_W(16)) d1 (.clk(clk), .reset(reset), .bus(b1));
    if_ctrl #(.MEM_LAT(3), .CNT_W(3))  d3 (.clk(clk), .reset(reset), .bus(b3));

`ifdef IF_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Model: an instruction becomes available at a known edge number after each PC update
    int          lat[2]  = '{1, 3};
    int          cmax[2] = '{65535, 7};
    bit          have[2] = '{0, 0};
    logic [31:0] irm[2]  = '{0, 0};
    int          cap[2]  = '{0, 0};
    int          fc[2]   = '{0, 0};
    int          sc[2]   = '{0, 0};
    int          edge_n  = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s at edge %0d observed=%h expected=%h", tag, edge_n, obs, exp);
    endtask

    task automatic check_dut(int m, logic [31:0] o_ir, logic o_v, logic o_lden, logic o_sel,
                             logic [31:0] o_imm, logic [15:0] o_fc, logic [15:0] o_sc);
        string p = (m == 0) ? "lat1" : "lat3";
        bit v = !reset && have[m] && !halt;
        bit x = v && ir_ready;
        chk({p, ".ir_valid"}, 32'(o_v), 32'(v));
        chk({p, ".PC_lden"}, 32'(o_lden), 32'(x));
        chk({p, ".PC_sel"}, 32'(o_sel), 32'(x && br_req));
        chk({p, ".PC_immed"}, o_imm, x ? br_immed : 32'd0);
        chk({p, ".ir"}, o_ir, reset ? 32'd0 : irm[m]);
        chk({p, ".fetch_cnt"}, 32'(o_fc), (PERF && !reset) ? 32'(fc[m]) : 32'd0);
        chk({p, ".stall_cnt"}, 32'(o_sc), (PERF && !reset) ? 32'(sc[m]) : 32'd0);
    endtask

    task automatic upd(int m);
        bit x = have[m] && !halt && ir_ready;
        if (reset) begin
            have[m] = 0; irm[m] = '0; fc[m] = 0; sc[m] = 0;
            cap[m] = edge_n + lat[m];
        end else if (!have[m]) begin
            if (edge_n == cap[m]) begin
                have[m] = 1;
                irm[m] = instr;
            end
        end else if (x) begin
            have[m] = 0;
            cap[m] = edge_n + lat[m];
            fc[m] = (fc[m] < cmax[m]) ? fc[m] + 1 : fc[m];
        end else begin
            sc[m] = (sc[m] < cmax[m]) ? sc[m] + 1 : sc[m];
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        check_dut(0, b1.ir, b1.ir_valid, b1.PC_lden, b1.PC_sel, b1.PC_immed, b1.fetch_cnt, b1.stall_cnt);
        check_dut(1, b3.ir, b3.ir_valid, b3.PC_lden, b3.PC_sel, b3.PC_immed,
                  16'(b3.fetch_cnt), 16'(b3.stall_cnt));
        @(posedge clk);
        edge_n++;
        upd(0);
        upd(1);
        #1;
        instr = $urandom;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        // reset with ready and branch request asserted
        reset = 1; ir_ready = 1; br_req = 1; br_immed = 32'hdead_beef;
        run(3);
        // sequential fetch
        reset = 0; br_req = 0; halt = 0; ir_ready = 1;
        run(8);
        // branch request held across transfer and non-transfer cycles
        br_req = 1; br_immed = 32'd3;
        run(4);
        br_req = 0;
        // backpressure then release
        ir_ready = 0;
        run(10);
        ir_ready = 1;
        run(1);
        // halt raised in the second WAIT cycle, released with ready high
        reset = 1;
        run(1);
        reset = 0;
        run(1);
        halt = 1;
        run(6);
        halt = 0;
        run(3);
        // reset while an instruction is pending
        ir_ready = 0;
        run(5);
        reset = 1;
        run(1);
        reset = 0; ir_ready = 1;
        run(8);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            reset    = ($urandom_range(39) == 0);
            halt     = ($urandom_range(3) == 0);
            ir_ready = $urandom_range(1) == 1;
            br_req   = $urandom_range(1) == 1;
            br_immed = $urandom;
            cyc();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/if_ctrl.md
# if_ctrl

Fetch sequencer for the instruction-fetch stage. It drives the PC load controls (`PC_lden`, `PC_sel`, `PC_immed`) and waits a fixed instruction-memory latency after each PC update. It then latches the fetched word into an instruction register and hands it to decode over a valid/ready handshake. The block sits between `ifstage` and the decode stage and is the only agent that advances the PC.

## Interface
- `MEM_LAT`, default 1: cycles from PC update to a stable `instr`; legal range 1..7.
- `CNT_W`, default 16: width of the performance counters.

- `clk` in 1: sole clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `instr` in 32: instruction word from `ifstage`.
- `br_req` in 1: from decode; on a transfer, the next PC takes the branch path.
- `br_immed` in 32: from decode; branch immediate, forwarded to `PC_immed`.
- `halt` in 1: freezes instruction issue while high.
- `ir_ready` in 1: decode accepts the instruction register this cycle.
- `PC_sel` out 1: PC mux select (0 = PC+4, 1 = branch path).
- `PC_lden` out 1: PC load enable.
- `PC_immed` out 32: branch immediate into `ifstage`.
- `ir` out 32: instruction register.
- `ir_valid` out 1: `ir` holds an unconsumed instruction.
- `fetch_cnt` out CNT_W: number of transferred instructions.
- `stall_cnt` out CNT_W: number of backpressure and halt cycles.

## Operation
- The FSM has two states, WAIT and VALID, plus a `wait_cnt` counter (3 bits), an `ir` register and a `vld` flag.
- **Reset** (synchronous) sets:
  - state to WAIT and `wait_cnt` to MEM_LAT;
  - `ir` to 0 and `vld` to 0;
  - both counters to 0.
  - All outputs read 0 during a reset cycle, including the combinational ones, which are gated by `!reset`.
- **WAIT state**:
  - `wait_cnt` decrements each cycle.
  - On the edge ending the cycle where `wait_cnt` == 1: `ir` <= `instr`, `vld` <= 1, state goes to VALID.
- **VALID state**:
  - `ir_valid` = `vld & !halt`.
  - A transfer happens when `ir_valid & ir_ready`.
- **Transfer cycle** (Mealy outputs, combinational):
  - `PC_lden` = 1, `PC_sel` = `br_req`, `PC_immed` = `br_immed`.
  - At the edge: `vld` <= 0, `wait_cnt` <= MEM_LAT, state goes to WAIT.
- **Non-transfer cycles**: `PC_lden` = 0, `PC_sel` = 0, `PC_immed` = 0. `br_req` and `br_immed` are ignored outside transfer cycles.
- **`halt`**:
  - In VALID: masks `ir_valid` and blocks the transfer; `ir` is held.
  - In WAIT: the countdown completes normally; the FSM enters VALID and then holds.
- **`ir`** changes only on the capture edge. It holds its value through VALID and the following WAIT, so decode must use `ir` only while `ir_valid`=1.
- **Reset mid-operation**, in any state: behaviour is identical to power-on reset. Any pending instruction is discarded and the fetch restarts from the PC value that `ifstage` itself reset to.

## Timing
- Reset deasserts before edge E0. The first WAIT cycle is the cycle after E0, and `ir_valid` rises MEM_LAT cycles after E0.
- With `ir_ready` held at 1 and `halt`=0, the steady-state issue interval is MEM_LAT+1 cycles per instruction.
- `PC_lden` is high for exactly one cycle per transfer.
- The PC updates on the same edge that drops `vld`.
- `ir_ready` to `PC_lden` is a combinational path. The decode stage must drive `ir_ready`, `br_req` and `br_immed` from registers.
- Boundary cases:
  - `halt` and `ir_ready` both high: no transfer.
  - `halt` falling with `ir_ready` high: the transfer happens in that same cycle.

## Configuration
- **`IF_CTRL_PERF_EN` defined**:
  - `fetch_cnt` increments on every transfer.
  - `stall_cnt` increments on every cycle with `vld`=1 and no transfer, covering both halt and backpressure cycles.
  - Both counters saturate at all-ones and clear on reset.
- **`IF_CTRL_PERF_EN` undefined**: the counter registers are not built, and `fetch_cnt` and `stall_cnt` are tied to 0.
- The port list is identical in both builds.

## Test plan
- **Reset check:** hold `reset`=1 for 3 cycles with `ir_ready`=1 and `br_req`=1 → every output is 0 in every reset cycle.
- **Sequential fetch:** MEM_LAT=1, `ir_ready`=1, `halt`=0, `br_req`=0, 4 instructions →
  - `ir_valid` pulses every 2nd cycle;
  - `PC_lden` is coincident with each pulse and `PC_sel`=0;
  - `ir` matches `instr` as sampled at each capture edge;
  - `fetch_cnt`=4 (PERF build).
- **Branch:** `br_req`=1 and `br_immed`=3 during the first transfer → that cycle shows `PC_lden`=1, `PC_sel`=1, `PC_immed`=3. With `br_req` held at 1 in a non-transfer cycle → `PC_sel`=0.
- **Backpressure:** `ir_ready`=0 for 5 cycles in VALID →
  - `PC_lden`=0 throughout and `ir` is stable;
  - `stall_cnt`=5;
  - raising `ir_ready` gives a transfer in that same cycle.
- **Halt plus latency:** MEM_LAT=3, `halt`=1 asserted in the 2nd WAIT cycle →
  - `vld` is set 3 cycles after the PC update, but `ir_valid`=0 and there is no transfer;
  - releasing `halt` with `ir_ready`=1 gives the transfer in the release cycle.
- **Reset mid-operation:** `reset` pulsed for 1 cycle while in VALID with `ir_valid`=1 →
  - `ir_valid`=0 and `ir`=0 the next cycle;
  - the counters read 0;
  - a new capture occurs MEM_LAT cycles after reset is released.
